// File: rtl/segment_display_decoder_pkg.sv
// segment_display_decoder_pkg: glyph table, FSM states and illegal-glyph marker shared by the decoder.
package segment_display_decoder_pkg;
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [3:0] ILLEGAL_NIBBLE = 4'h0;
  typedef enum logic [1:0] {WAIT_SEL, SETTLE, HOLD} state_t;
endpackage

// File: rtl/segment_glyph_lookup.sv
// segment_glyph_lookup: maps an active-low GFEDCBA pattern to its hex nibble and a legal flag.
module segment_glyph_lookup
  import segment_display_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);
  always_comb begin
    nibble = ILLEGAL_NIBBLE;
    legal = 1'b0;
    for (int i = 0; i < 16; i++)
      if (pattern == GLYPHS[i]) begin
        nibble = 4'(i);
        legal = 1'b1;
      end
  end
endmodule

// File: rtl/segment_display_decoder.sv
// segment_display_decoder: debounces a multiplexed 7-segment scan into a hex frame.
// Define SEGMENT_DECODER_ERR_COUNT_EN to enable the saturating o_ERR_COUNT counter.
module segment_display_decoder
  import segment_display_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic [6:0]              i_SEG,
  input  logic [NUM_DIGITS-1:0]   i_DIGIT_SEL,
  output logic [4*NUM_DIGITS-1:0] o_VALUE,
  output logic                    o_VALID,
  output logic                    o_ERR,
  output logic [7:0]              o_ERR_COUNT
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] idx, sel_q;
  logic [6:0] seg_q;
  logic [7:0] cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] frame_q;
  logic [NUM_DIGITS-1:0] cap_q;
  logic legal_sel, same_sel, settle_ok, hold_ok, load, acc, glyph_legal;
  logic [3:0] nibble;
  segment_glyph_lookup u_lookup (.pattern(i_SEG), .nibble(nibble), .legal(glyph_legal));
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!i_DIGIT_SEL[i]) idx = IW'(i);
  end
  assign legal_sel = $onehot(~i_DIGIT_SEL);
  assign same_sel = legal_sel && idx == sel_q;
  assign settle_ok = state_q == SETTLE && same_sel && i_SEG == seg_q;
  assign hold_ok = state_q == HOLD && same_sel;
  // Anything that is not a continued settle or hold restarts from a fresh latch.
  assign load = legal_sel && !settle_ok && !hold_ok;
  assign acc = (load && STABLE_CYCLES == 1) ||
               (settle_ok && ({1'b0, cnt_q} + 9'd1) >= 9'(STABLE_CYCLES));
  always_comb begin
    state_d = acc ? HOLD : (load || settle_ok) ? SETTLE : hold_ok ? HOLD : WAIT_SEL;
    cnt_d = load ? 8'd1 : settle_ok ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= WAIT_SEL;
      cnt_q <= '0;
      sel_q <= '0;
      seg_q <= '0;
      frame_q <= '0;
      cap_q <= '0;
      o_VALUE <= '0;
      o_VALID <= 1'b0;
      o_ERR <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (load) begin
        sel_q <= idx;
        seg_q <= i_SEG;
      end
      o_ERR <= acc && !glyph_legal;
      o_VALID <= &cap_q;
      if (&cap_q) o_VALUE <= frame_q;
      // A digit accepted during frame completion seeds the next frame.
      cap_q <= (&cap_q ? '0 : cap_q) | (acc && glyph_legal ? ~i_DIGIT_SEL : '0);
      if (acc && glyph_legal) frame_q[idx*4 +: 4] <= nibble;
    end
  end
`ifdef SEGMENT_DECODER_ERR_COUNT_EN
  logic [7:0] err_cnt_q;
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) err_cnt_q <= '0;
    else if (o_ERR && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end
  assign o_ERR_COUNT = err_cnt_q;
`else
  assign o_ERR_COUNT = '0;
`endif
endmodule

// File: tb/tb_segment_display_decoder.sv
// tb_segment_display_decoder: directed and random scans checked against a run-level reference model.
module tb_segment_display_decoder;
  localparam int S = 4;
  logic clk = 1'b0, rst;
  logic [6:0] seg;
  logic [3:0] sel;
  logic [15:0] value;
  logic valid, err;
  logic [7:0] err_count;
  always #5 clk = ~clk;
  segment_display_decoder #(.STABLE_CYCLES(S), .NUM_DIGITS(4)) dut (
    .i_CLK(clk), .i_RST(rst), .i_SEG(seg), .i_DIGIT_SEL(sel),
    .o_VALUE(value), .o_VALID(valid), .o_ERR(err), .o_ERR_COUNT(err_count)
  );
  int checks = 0, failures = 0;
  int vcnt = 0, ecnt = 0;
  always @(negedge clk) if (!rst) begin
    if (valid) vcnt++;
    if (err) ecnt++;
  end
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] m_buf [4];
  logic [3:0] m_cap, prev_sel;
  logic [6:0] prev_seg;
  logic [15:0] m_val;
  int m_v = 0, m_e = 0, m_errcnt, run_len;
  bit eligible, accepted, holding;
  function automatic int decode(logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
    return -1;
  endfunction
  function automatic int digit_of(logic [3:0] s);
    for (int i = 0; i < 4; i++) if (!s[i]) return i;
    return 0;
  endfunction
  function automatic logic [3:0] dsel(int d);
    logic [3:0] one = 4'b0001;
    return ~(one << d);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_buf[i] = 4'h0;
    m_cap = 4'h0; m_val = 16'h0; m_errcnt = 0;
    prev_sel = 4'hF; prev_seg = 7'h7F; run_len = 0;
    eligible = 0; accepted = 0; holding = 0;
  endtask
  task automatic accept(int d, logic [6:0] p);
    int g = decode(p);
    if (g < 0) begin
      m_e++;
      if (m_errcnt < 255) m_errcnt++;
    end else begin
      m_buf[d] = 4'(g);
      m_cap[d] = 1'b1;
      if (m_cap == 4'hF) begin
        m_v++;
        m_val = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
        m_cap = 4'h0;
      end
    end
  endtask
  // A run is a stretch of constant select and pattern; a run is captured once it lasts S cycles,
  // unless the same digit was already captured and its select never went away.
  task automatic drive(logic [3:0] s, logic [6:0] p, int len);
    if (s != prev_sel || p != prev_seg) begin
      if (s != prev_sel) holding = 0;
      run_len = 0; accepted = 0;
      eligible = ($countones(~s) == 1) && !holding;
      prev_sel = s; prev_seg = p;
    end
    run_len += len;
    if (eligible && !accepted && run_len >= S) begin
      accepted = 1; holding = 1;
      accept(digit_of(s), p);
    end
    sel = s; seg = p;
    repeat (len) @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; sel = 4'hF; seg = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
  endtask
  function automatic int exp_errcnt();
`ifdef SEGMENT_DECODER_ERR_COUNT_EN
    return m_errcnt;
`else
    return 0;
`endif
  endfunction
  int v0, e0;
  initial begin
    do_reset();
    chk("reset_value", 32'(value), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_errcnt", 32'(err_count), 0);
    rst = 1'b0;
    for (int d = 0; d < 4; d++) drive(dsel(d), glyph[d], 6);
    drive(4'hF, 7'h7F, 3);
    chk("scan_valid_cnt", 32'(vcnt), 1);
    chk("scan_value", 32'(value), 32'h3210);
    chk("scan_model", 32'(value), 32'(m_val));
    drive(dsel(0), glyph[0], 6); drive(dsel(1), glyph[1], 3);
    drive(dsel(2), glyph[2], 6); drive(dsel(3), glyph[3], 6);
    drive(4'hF, 7'h7F, 3);
    chk("short_no_valid", 32'(vcnt), 1);
    drive(dsel(1), glyph[1], 4);
    drive(4'hF, 7'h7F, 3);
    chk("short_then_valid", 32'(vcnt), 2);
    chk("short_value", 32'(value), 32'h3210);
    e0 = ecnt;
    drive(dsel(0), glyph[0], 6); drive(dsel(1), glyph[1], 6);
    drive(dsel(2), 7'h7F, 6); drive(dsel(3), glyph[3], 6);
    drive(4'hF, 7'h7F, 3);
    chk("blank_err_once", 32'(ecnt - e0), 1);
    chk("blank_no_frame", 32'(vcnt), 2);
`ifdef SEGMENT_DECODER_ERR_COUNT_EN
    chk("blank_errcnt", 32'(err_count), 1);
`else
    chk("blank_errcnt", 32'(err_count), 0);
`endif
    v0 = vcnt; e0 = ecnt;
    drive(4'b1100, glyph[5], 10);
    drive(4'hF, 7'h7F, 3);
    chk("twolow_no_valid", 32'(vcnt - v0), 0);
    chk("twolow_no_err", 32'(ecnt - e0), 0);
    do_reset();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) drive(dsel(d), glyph[d], 6);
    drive(dsel(3), glyph[3], 2);
    do_reset();
    chk("midreset_value", 32'(value), 0);
    chk("midreset_errcnt", 32'(err_count), 0);
    rst = 1'b0;
    v0 = vcnt;
    drive(dsel(0), 7'h0E, 6); drive(dsel(1), 7'h06, 6);
    drive(dsel(2), 7'h21, 6); drive(dsel(3), 7'h46, 6);
    drive(4'hF, 7'h7F, 3);
    chk("postreset_one_valid", 32'(vcnt - v0), 1);
    chk("postreset_value", 32'(value), 32'hCDEF);
    e0 = ecnt;
    for (int i = 0; i < 150; i++) begin
      drive(dsel(0), 7'h7F, 4);
      drive(dsel(1), 7'h7F, 4);
    end
    drive(4'hF, 7'h7F, 3);
    chk("sat_err_pulses", 32'(ecnt - e0), 300);
`ifdef SEGMENT_DECODER_ERR_COUNT_EN
    chk("sat_errcnt", 32'(err_count), 255);
`else
    chk("sat_errcnt", 32'(err_count), 0);
`endif
    chk("sat_errcnt_model", 32'(err_count), 32'(exp_errcnt()));
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 250; i++) begin
      logic [3:0] s;
      logic [6:0] p;
      s = ($urandom_range(0, 9) < 8) ? dsel($urandom_range(0, 3)) : 4'($urandom);
      p = ($urandom_range(0, 3) != 0) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
      drive(s, p, $urandom_range(1, 7));
    end
    drive(4'hF, 7'h7F, 4);
    chk("rand_valid_cnt", 32'(vcnt), 32'(m_v));
    chk("rand_err_cnt", 32'(ecnt), 32'(m_e));
    chk("rand_value", 32'(value), 32'(m_val));
    chk("rand_errcnt", 32'(err_count), 32'(exp_errcnt()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/segment_display_decoder.md
SEGMENT_DISPLAY_DECODER -- requirements
Module: segment_display_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is accepted (legal range 1..255).
REQ-002 Parameter NUM_DIGITS, default 4: number of multiplexed digits captured per frame (legal range 1..8).
REQ-003 i_CLK  input  1  single clock; all state updates on rising edge.
REQ-004 i_RST  input  1  asynchronous, active-high reset.
REQ-005 i_SEG  input  7  segment bus, active-low, format GFEDCBA (bit 6 = G, bit 0 = A).
REQ-006 i_DIGIT_SEL  input  NUM_DIGITS  digit select, active-low, one-hot when legal; bit 0 = least significant nibble.
REQ-007 o_VALUE  output  4*NUM_DIGITS  last complete decoded frame; digit k occupies bits [4k+3:4k].
REQ-008 o_VALID  output  1  one-cycle pulse when o_VALUE updates.
REQ-009 o_ERR  output  1  one-cycle pulse when an accepted pattern is not a legal hex glyph.
REQ-010 o_ERR_COUNT  output  8  saturating count of o_ERR pulses (see Configuration).

Function
REQ-011 Legal glyphs, 0-F in order: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, GFEDCBA, active-low); each glyph decodes to its index.
REQ-012 Select is "legal" only when exactly one i_DIGIT_SEL bit is low.
REQ-013 FSM states: WAIT_SEL, SETTLE, HOLD.
REQ-014 WAIT_SEL: on legal select, latch select index and i_SEG, load stability counter with 1, go SETTLE.
REQ-015 SETTLE: each cycle with same select and same i_SEG increments counter; on counter reaching STABLE_CYCLES, the pattern is accepted and the FSM goes HOLD.
REQ-016 SETTLE: select change or i_SEG change restarts from REQ-014 behaviour in the same cycle (legal select) or goes WAIT_SEL (illegal select).
REQ-017 STABLE_CYCLES = 1: pattern accepted in the same cycle it is first latched.
REQ-018 Accept of legal glyph: nibble written into frame buffer slot for that digit; digit marked captured.
REQ-019 Accept of illegal glyph: o_ERR pulses next cycle; slot and captured mark unchanged.
REQ-020 HOLD: stays until select changes; then behaves as WAIT_SEL in that cycle; a same-digit refresh is never recaptured until another select is seen.
REQ-021 When all NUM_DIGITS captured marks are set, o_VALUE loads the frame buffer and o_VALID pulses the following cycle; all captured marks clear in that same cycle.
REQ-022 A digit accepted in the frame-completion cycle is counted toward the next frame.
REQ-023 Duplicate capture of one digit within a frame overwrites its slot; frame order is irrelevant.

Reset
REQ-024 While i_RST high: FSM WAIT_SEL, counter 0, frame buffer 0, captured marks 0, o_VALUE 0, o_VALID 0, o_ERR 0, o_ERR_COUNT 0.
REQ-025 Reset mid-SETTLE or mid-frame discards all partial state; first o_VALID after reset requires a full new frame.

Configuration
REQ-026 Macro SEGMENT_DECODER_ERR_COUNT_EN defined: o_ERR_COUNT increments on each o_ERR pulse, saturating at 255.
REQ-027 Macro undefined: counter logic absent; o_ERR_COUNT tied to 0; o_ERR unaffected.

Structure
REQ-028 Shared package holds the 16-entry glyph table constant, the FSM state enumeration, and the illegal-glyph marker.
REQ-029 One sub-module, segment_glyph_lookup: combinational 7-bit pattern to 4-bit nibble plus legal flag.

Verification
REQ-030 Defaults; scan digits 0..3 showing 40,79,24,30 for 6 cycles each -> o_VALID once, o_VALUE = 16'h3210.
REQ-031 Digit 1 held only 3 cycles with STABLE_CYCLES=4, others 6 -> no o_VALID until digit 1 held >= 4 cycles.
REQ-032 Digit 2 shows 7F (blank) -> o_ERR pulses once, o_ERR_COUNT = 1 with macro, 0 without; frame not completed.
REQ-033 i_DIGIT_SEL = 4'b1100 for 10 cycles -> FSM stays WAIT_SEL, no captures.
REQ-034 i_RST asserted after digits 0..2 captured, then full scan of 0E,06,21,46 -> single o_VALID, o_VALUE = 16'hCDEF.
REQ-035 Repeat 300 illegal accepts with macro -> o_ERR_COUNT saturates at 255.
